packet_inspector: RTL
=====================

// Module: packet_inspector
// PURPOSE
// Byte-stream deep-packet inspector that produces the rule_violation / pattern_violation
// flags consumed by the firewall state machine, and obeys its firewall_block output.
// Sits inline on the ingress path: checks header rules and a payload signature, forwards
// clean traffic through a one-deep registered stage, and truncates or discards offending
// or blocked traffic.
// PARAMETERS
// MAX_LEN     64            max legal packet length in bytes (1..255)
// MIN_LEN     4             min legal packet length in bytes (1..MAX_LEN)
// BLOCK_PORT  8'h17         forbidden value of header byte index 1
// SIG         32'hDEADBEEF  payload signature; the first byte of the match is in SIG[31:24]
// PORTS
// clk                clk  in   1   single clock, rising edge
// rst_n              in   1   asynchronous active-low reset
// in_valid           in   1   input byte valid
// in_data            in   8   input byte
// in_sop / in_eop    in   1   first / last byte of a packet
// in_ready           out  1   input handshake; a byte is accepted when in_valid && in_ready
// out_valid          out  1   output byte valid
// out_data           out  8   output byte
// out_sop / out_eop  out  1   packet delimiters on the output
// out_err            out  1   with out_eop: packet truncated by a violation
// out_ready          in   1   downstream ready
// firewall_block     in   1   from the firewall FSM; when high, discard all traffic
// rule_violation     out  1   1-cycle pulse
// pattern_violation  out  1   1-cycle pulse
// drop_count         out  16  saturating count of packets truncated or discarded
// BEHAVIOUR
// - Reset: all outputs are 0, except in_ready=1. FSM=IDLE. The counter and shift register are cleared.
// - in_ready = !out_valid || out_ready (skid-free single stage); in_ready is never gated by state.
// - Latency: a forwarded byte appears on out_* exactly 1 cycle after acceptance.
//   Violation pulses are registered and assert in that same cycle.
// - out_* stay stable while out_valid && !out_ready. A pending byte is never retracted,
//   even if firewall_block rises.
// - FSM states: IDLE, HEADER (byte idx 0-1), PAYLOAD, DROP.
//   IDLE: a non-sop byte is accepted and discarded. A sop byte goes to HEADER, and sets
//     byte_cnt=1 (8-bit, saturates at 255).
//   HEADER->PAYLOAD after idx 1. Any state ->IDLE on an accepted eop.
//     An eop that is also a violation trigger ->IDLE.
//   DROP: accept and discard bytes until eop, then go to IDLE. No pulses are issued in DROP.
// - Rule violation (at most one per packet), triggered on the accepted byte when any of:
//   (a) idx 1 == BLOCK_PORT;
//   (b) byte_cnt would exceed MAX_LEN;
//   (c) eop with byte_cnt < MIN_LEN;
//   (d) sop arrives while in HEADER/PAYLOAD. This closes the old packet as a violation;
//       the sop byte starts a new packet.
// - Pattern violation: a 32-bit shift register of accepted bytes, cleared at sop.
//   A match is valid only when >=4 bytes of the current packet have been seen.
// - Trigger handling:
//   - The triggering byte is forwarded with out_eop=1, out_err=1.
//   - FSM goes to DROP (or IDLE if the trigger is eop).
//   - drop_count increments.
//   - If rule and pattern trigger on the same byte, both pulse and drop_count increments once.
// - firewall_block high:
//   - Accepted bytes are not forwarded.
//   - Detection and pulses continue.
//   - drop_count increments once per packet that has any byte discarded while blocked.
//   - Block asserting mid-packet: the forwarded portion is left without eop. Downstream
//     handles this via the next out_sop.
// - Reset mid-packet: immediate return to IDLE; the partial output is abandoned.
// STRUCTURE
// - fw_pkg: state encodings, default SIG/BLOCK_PORT/MAX_LEN, and the rule-cause enum
//   (LEN_HI, LEN_LO, PORT, NO_EOP).
// - Sub-module sig_matcher: shift register, match-armed counter and 32-bit compare.
//   Clear on sop, shift on accept, combinational hit.
// TESTING
// - 10-byte packet, idx1=8'h50, out_ready=1 -> 10 bytes out, 1-cycle latency,
//   no pulses, drop_count=0.
// - Packet with idx1=8'h17 -> rule_violation pulse one cycle after byte 1.
//   Out: 2 bytes, 2nd with eop+err. Remaining bytes are discarded; drop_count=1.
// - Payload ..DE AD BE EF.. at bytes 5-8 -> pattern pulse with byte 8 out (eop+err).
//   Bytes 9+ are discarded.
// - 70-byte packet, MAX_LEN=64 -> rule pulse on byte 65, out eop+err; 2-byte packet ->
//   rule pulse on eop.
// - out_ready held low 5 cycles mid-packet -> out_* stable, in_ready=0, no byte loss
//   or duplication.
// - firewall_block=1 throughout a packet containing SIG -> nothing out,
//   pattern pulse still fires, drop_count+1.
//   rst_n low mid-packet -> all outputs 0, in_ready=1.

Source files
------------

// File: rtl/packet_inspector_pkg.sv
// Shared types and defaults for the inline packet inspector.
package packet_inspector_pkg;

    localparam int          DEF_MAX_LEN    = 64;
    localparam int          DEF_MIN_LEN    = 4;
    localparam logic [7:0]  DEF_BLOCK_PORT = 8'h17;
    localparam logic [31:0] DEF_SIG        = 32'hDEADBEEF;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_HEADER,
        ST_PAYLOAD,
        ST_DROP
    } state_t;

    // Cause of the most recent rule violation, kept for debug visibility.
    typedef enum logic [2:0] {
        CAUSE_NONE,
        CAUSE_LEN_HI,
        CAUSE_LEN_LO,
        CAUSE_PORT,
        CAUSE_NO_EOP
    } rule_cause_t;

    // Saturating add of a small increment to the 16-bit drop counter.
    function automatic logic [15:0] sat_add16(input logic [15:0] a, input logic [1:0] b);
        logic [16:0] s;
        s = {1'b0, a} + {15'b0, b};
        return s[16] ? 16'hFFFF : s[15:0];
    endfunction

endpackage

// File: rtl/packet_inspector_if.sv
// Byte-stream bus with packet delimiters.
// Handshake: a byte transfers on a rising clk edge where valid && ready; the master
// holds valid/data/sop/eop/err stable until that edge and never withdraws valid early.
interface packet_inspector_if;
    logic       valid;
    logic       ready;
    logic [7:0] data;
    logic       sop;
    logic       eop;
    logic       err;

    modport master (output valid, output data, output sop, output eop, output err, input ready);
    modport slave  (input valid, input data, input sop, input eop, output ready);
endinterface

// File: rtl/packet_inspector_sig_matcher.sv
// Payload signature matcher: 32-bit shift register of accepted bytes plus a counter
// that arms the compare once four bytes of the current packet have been seen.
module packet_inspector_sig_matcher
    import packet_inspector_pkg::*;
#(
    parameter logic [31:0] SIG = DEF_SIG
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       accept,
    input  logic       sop,
    input  logic [7:0] data,
    output logic       hit
);

    logic [31:0] shift_q, shift_d;
    logic [2:0]  armed_q, armed_d;

    // Next shift contents include the byte being accepted so the hit lines up with it.
    always_comb begin
        shift_d = shift_q;
        armed_d = armed_q;
        if (accept) begin
            if (sop) begin
                shift_d = {24'h0, data};
                armed_d = 3'd1;
            end else begin
                shift_d = {shift_q[23:0], data};
                armed_d = (armed_q >= 3'd4) ? 3'd4 : armed_q + 3'd1;
            end
        end
        hit = accept && (armed_d == 3'd4) && (shift_d == SIG);
    end

    // Register the shift window and arming count.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            shift_q <= 32'h0;
            armed_q <= 3'd0;
        end else begin
            shift_q <= shift_d;
            armed_q <= armed_d;
        end
    end

endmodule

// File: rtl/packet_inspector.sv
// Inline deep-packet inspector: header rules, payload signature, one-deep output
// register, truncation of offending packets and discard under firewall block.
module packet_inspector
    import packet_inspector_pkg::*;
#(
    parameter int          MAX_LEN    = DEF_MAX_LEN,
    parameter int          MIN_LEN    = DEF_MIN_LEN,
    parameter logic [7:0]  BLOCK_PORT = DEF_BLOCK_PORT,
    parameter logic [31:0] SIG        = DEF_SIG
) (
    input  logic                        clk,
    input  logic                        rst_n,
    packet_inspector_if.slave           in_if,
    packet_inspector_if.master          out_if,
    input  logic                        firewall_block,
    output logic                        rule_violation,
    output logic                        pattern_violation,
    output logic [15:0]                 drop_count,
    output state_t                      state_dbg,
    output rule_cause_t                 rule_cause_dbg
);

    state_t      state_q, state_d;
    logic [7:0]  byte_cnt_q, byte_cnt_d;
    logic        counted_q, counted_d;
    logic        out_valid_q, out_valid_d;
    logic [7:0]  out_data_q, out_data_d;
    logic        out_sop_q, out_sop_d;
    logic        out_eop_q, out_eop_d;
    logic        out_err_q, out_err_d;
    logic        rule_q, rule_d;
    logic        pat_q, pat_d;
    logic [15:0] drop_cnt_q, drop_cnt_d;
    rule_cause_t cause_q, cause_d;

    logic       in_ready, accept, active;
    logic       start_pkt, cont_pkt, close_old;
    logic [8:0] cnt_inc;
    logic       len_hi, len_lo, port_hit, pkt_rule, pkt_pat, trig, fwd;
    logic       new_count, old_count, sig_hit;

    // Single-stage pipe: space exists when the slot is empty or draining this cycle.
    assign in_ready  = !out_valid_q || out_if.ready;
    assign accept    = in_if.valid && in_ready;
    assign active    = (state_q == ST_HEADER) || (state_q == ST_PAYLOAD);
    // DROP swallows everything up to eop, including any sop seen there.
    assign start_pkt = accept && in_if.sop && (state_q != ST_DROP);
    assign cont_pkt  = accept && !in_if.sop && active;
    assign close_old = accept && in_if.sop && active;
    assign cnt_inc   = start_pkt ? 9'd1 : {1'b0, byte_cnt_q} + 9'd1;
    assign len_hi    = cont_pkt && (cnt_inc > 9'(MAX_LEN));
    assign len_lo    = (start_pkt || cont_pkt) && in_if.eop && (cnt_inc < 9'(MIN_LEN));
    assign port_hit  = cont_pkt && (byte_cnt_q == 8'd1) && (in_if.data == BLOCK_PORT);
    assign pkt_rule  = len_hi || len_lo || port_hit;
    assign pkt_pat   = cont_pkt && sig_hit;
    assign trig      = pkt_rule || pkt_pat;
    assign fwd       = (start_pkt || cont_pkt) && !firewall_block;
    // Each packet is counted at most once, whether truncated or discarded while blocked.
    assign new_count = (start_pkt || cont_pkt) && (firewall_block || trig) &&
                       (start_pkt || !counted_q);
    assign old_count = close_old && !counted_q;

    packet_inspector_sig_matcher #(.SIG(SIG)) u_sig_matcher (
        .clk    (clk),
        .rst_n  (rst_n),
        .accept (accept),
        .sop    (in_if.sop),
        .data   (in_if.data),
        .hit    (sig_hit)
    );

    // Next-state, output-stage and counter logic for one accepted byte.
    always_comb begin
        state_d     = state_q;
        byte_cnt_d  = byte_cnt_q;
        counted_d   = counted_q;
        out_valid_d = out_if.ready ? 1'b0 : out_valid_q;
        out_data_d  = out_data_q;
        out_sop_d   = out_sop_q;
        out_eop_d   = out_eop_q;
        out_err_d   = out_err_q;
        rule_d      = pkt_rule || close_old;
        pat_d       = pkt_pat;
        drop_cnt_d  = sat_add16(drop_cnt_q, {1'b0, new_count} + {1'b0, old_count});
        cause_d     = cause_q;
        if (close_old)     cause_d = CAUSE_NO_EOP;
        else if (port_hit) cause_d = CAUSE_PORT;
        else if (len_hi)   cause_d = CAUSE_LEN_HI;
        else if (len_lo)   cause_d = CAUSE_LEN_LO;
        if (start_pkt || cont_pkt) begin
            byte_cnt_d = cnt_inc[8] ? 8'hFF : cnt_inc[7:0];
            counted_d  = new_count || (cont_pkt && counted_q);
            if (in_if.eop)      state_d = ST_IDLE;
            else if (trig)      state_d = ST_DROP;
            else if (start_pkt) state_d = ST_HEADER;
            else                state_d = ST_PAYLOAD;
        end else if (accept && (state_q == ST_DROP) && in_if.eop) begin
            state_d = ST_IDLE;
        end
        if (fwd) begin
            out_valid_d = 1'b1;
            out_data_d  = in_if.data;
            out_sop_d   = start_pkt;
            out_eop_d   = in_if.eop || trig;
            out_err_d   = trig;
        end
    end

    // State, output stage, pulses and counter, all cleared asynchronously.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            byte_cnt_q  <= 8'd0;
            counted_q   <= 1'b0;
            out_valid_q <= 1'b0;
            out_data_q  <= 8'd0;
            out_sop_q   <= 1'b0;
            out_eop_q   <= 1'b0;
            out_err_q   <= 1'b0;
            rule_q      <= 1'b0;
            pat_q       <= 1'b0;
            drop_cnt_q  <= 16'd0;
            cause_q     <= CAUSE_NONE;
        end else begin
            state_q     <= state_d;
            byte_cnt_q  <= byte_cnt_d;
            counted_q   <= counted_d;
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
            out_sop_q   <= out_sop_d;
            out_eop_q   <= out_eop_d;
            out_err_q   <= out_err_d;
            rule_q      <= rule_d;
            pat_q       <= pat_d;
            drop_cnt_q  <= drop_cnt_d;
            cause_q     <= cause_d;
        end
    end

    assign in_if.ready       = in_ready;
    assign out_if.valid      = out_valid_q;
    assign out_if.data       = out_data_q;
    assign out_if.sop        = out_sop_q;
    assign out_if.eop        = out_eop_q;
    assign out_if.err        = out_err_q;
    assign rule_violation    = rule_q;
    assign pattern_violation = pat_q;
    assign drop_count        = drop_cnt_q;
    assign state_dbg         = state_q;
    assign rule_cause_dbg    = cause_q;

endmodule
